// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and the default bit period.
package uart_pkg;
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;
endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, start-bit recheck at half period,
// 8 data bits LSB first, stop-bit check. done_o/frame_err_o strobe in the sample cycle.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic       done_o,
  output logic       frame_err_o,
  output logic [7:0] byte_o
);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             ferr_wait_q, ferr_wait_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      ferr_wait_q <= 1'b0;
    end else begin
      sync1_q     <= rxd_i;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      ferr_wait_q <= ferr_wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    ferr_wait_d = ferr_wait_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        // After a bad stop bit, hold here until the line returns high.
        if (ferr_wait_q) begin
          if (sync2_q) begin
            ferr_wait_d = 1'b0;
            state_d     = RX_IDLE;
          end
        end else if (cnt_q == LAST) begin
          cnt_d = '0;
          if (sync2_q) state_d = RX_IDLE;
          else ferr_wait_d = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
    endcase
  end

  always_comb begin
    done_o      = (state_q == RX_STOP) && !ferr_wait_q && (cnt_q == LAST) && sync2_q;
    frame_err_o = (state_q == RX_STOP) && !ferr_wait_q && (cnt_q == LAST) && !sync2_q;
    byte_o      = shift_q;
  end
endmodule

// File: rtl/uart_cpld_responder.sv
// CPU-bus UART: strobe edge detection, TX holding register + shifter FSM,
// RX holding register fed by uart_rx_core.
module uart_cpld_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdn,
  input  logic       wrn,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       bus_doe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  input  logic       rxd,
  output logic       txd,
  output logic       frame_err,
  output logic       rx_overrun
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rdn_q, wrn_q;
  logic             rd_rise, wr_fall;
  logic [7:0]       thr_q, thr_d;
  logic             thr_full_q, thr_full_d;
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tsre_q, tsre_d;
  logic             txd_q, txd_d;
  logic [7:0]       rx_hold_q, rx_hold_d;
  logic             data_ready_q, data_ready_d;
  logic             frame_err_q, rx_overrun_q, rx_overrun_d;
  logic             rx_done, rx_ferr;
  logic [7:0]       rx_byte;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i      (clk),
    .rst_i      (rst),
    .rxd_i      (rxd),
    .done_o     (rx_done),
    .frame_err_o(rx_ferr),
    .byte_o     (rx_byte)
  );

  // A write strobe while a read is in progress is ignored.
  assign rd_rise = rdn && !rdn_q;
  assign wr_fall = !wrn && wrn_q && rdn;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_q        <= 1'b0;
      wrn_q        <= 1'b0;
      thr_q        <= '0;
      thr_full_q   <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tsre_q       <= 1'b1;
      txd_q        <= 1'b1;
      rx_hold_q    <= '0;
      data_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rdn_q        <= rdn;
      wrn_q        <= wrn;
      thr_q        <= thr_d;
      thr_full_q   <= thr_full_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tsre_q       <= tsre_d;
      txd_q        <= txd_d;
      rx_hold_q    <= rx_hold_d;
      data_ready_q <= data_ready_d;
      frame_err_q  <= rx_ferr;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  always_comb begin
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tsre_d     = tsre_q;
    if (wr_fall && !thr_full_q) begin
      thr_d      = bus_din;
      thr_full_d = 1'b1;
    end
    case (tx_state_q)
      TX_IDLE: begin
        if (thr_full_q) begin
          tx_state_d = TX_START;
          tx_shift_d = thr_q;
          thr_full_d = 1'b0;
          tsre_d     = 1'b0;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      TX_DATA: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      default: begin
        // End of stop bit: chain straight into the next frame if one is waiting.
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          if (thr_full_q) begin
            tx_state_d = TX_START;
            tx_shift_d = thr_q;
            thr_full_d = 1'b0;
            tx_bit_d   = '0;
          end else begin
            tx_state_d = TX_IDLE;
            tsre_d     = 1'b1;
          end
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
    endcase
  end

  always_comb begin
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // A read completing in the same cycle as a new byte frees the register for it.
  always_comb begin
    rx_hold_d    = rx_hold_q;
    data_ready_d = data_ready_q;
    rx_overrun_d = 1'b0;
    if (rx_done) begin
      if (!data_ready_q || rd_rise) begin
        rx_hold_d    = rx_byte;
        data_ready_d = 1'b1;
      end else rx_overrun_d = 1'b1;
    end else if (rd_rise) begin
      data_ready_d = 1'b0;
    end
  end

  assign bus_doe    = !rdn;
  assign bus_dout   = rdn ? 8'h00 : rx_hold_q;
  assign data_ready = data_ready_q;
  assign tbre       = !thr_full_q;
  assign tsre       = tsre_q;
  assign txd        = txd_q;
  assign frame_err  = frame_err_q;
  assign rx_overrun = rx_overrun_q;
endmodule
